// File: rtl/cv32e40p_pkg.sv
// rtl/cv32e40p_pkg.sv - shared fault-tolerant ALU types and class indices
package cv32e40p_pkg;

  localparam int FT_N_ALU   = 4;
  localparam int FT_N_CLASS = 9;

  // Subunit class indices, shared with the ALU error counter
  localparam int FT_CLS_SHIFT   = 0;
  localparam int FT_CLS_LOGIC   = 1;
  localparam int FT_CLS_BITMAN  = 2;
  localparam int FT_CLS_BITCNT  = 3;
  localparam int FT_CLS_SHUFFLE = 4;
  localparam int FT_CLS_COMPARE = 5;
  localparam int FT_CLS_ABSCLIP = 6;
  localparam int FT_CLS_MINMAX  = 7;
  localparam int FT_CLS_DIV     = 8;

  typedef enum logic [1:0] {
    FT_TMR_SPARE = 2'd0,
    FT_TMR       = 2'd1,
    FT_DMR       = 2'd2,
    FT_FAILED    = 2'd3
  } ft_mode_e;

  function automatic ft_mode_e ft_target_mode(input int unsigned min_healthy);
    if (min_healthy >= 4)      return FT_TMR_SPARE;
    else if (min_healthy == 3) return FT_TMR;
    else if (min_healthy == 2) return FT_DMR;
    else                       return FT_FAILED;
  endfunction

endpackage

// File: rtl/cv32e40p_alu_ft_select.sv
// rtl/cv32e40p_alu_ft_select.sv - picks up to three lowest-indexed healthy ALUs
module cv32e40p_alu_ft_select
  import cv32e40p_pkg::*;
#(
  parameter int N_ALU = FT_N_ALU,
  parameter int IW    = $clog2(N_ALU)
) (
  input  logic [N_ALU-1:0]     health_i,
  output logic [N_ALU-1:0]     sel_mask_o,
  output logic [1:0]           h_o,
  output logic [2:0][IW-1:0]   idx_o
);

  logic [1:0] cnt;

  always_comb begin
    sel_mask_o = '0;
    idx_o      = '0;
    cnt        = 2'd0;
    for (int i = 0; i < N_ALU; i++) begin
      if (health_i[i] && cnt != 2'd3) begin
        sel_mask_o[i] = 1'b1;
        idx_o[cnt]    = IW'(i);
        cnt           = cnt + 2'd1;
      end
    end
    h_o = cnt;
  end

endmodule

// File: rtl/cv32e40p_alu_ft_voter.sv
// rtl/cv32e40p_alu_ft_voter.sv - majority voter and degradation tracker for the quad ALU
module cv32e40p_alu_ft_voter
  import cv32e40p_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int N_ALU   = FT_N_ALU,
  parameter int N_CLASS = FT_N_CLASS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            valid_i,
  input  logic [3:0]                      op_class_i,
  input  logic [N_ALU-1:0][DATA_W-1:0]    result_i,
  input  logic [N_ALU-1:0][N_CLASS-1:0]   permanent_faulty_i,
  input  logic                            clear_sticky_i,
  output logic                            valid_o,
  output logic [DATA_W-1:0]               result_o,
  output logic [N_ALU-1:0]                error_detected_o,
  output logic                            uncorrectable_o,
  output logic [N_ALU-1:0]                alu_sel_o,
  output logic [1:0]                      mode_o,
  output logic                            mode_change_o,
  output logic [N_ALU-1:0]                err_sticky_o
);

  localparam int IW = $clog2(N_ALU);

  logic [N_ALU-1:0]   health;
  logic [N_ALU-1:0]   sel_mask;
  logic [1:0]         h;
  logic [2:0][IW-1:0] idx;

  always_comb begin
    for (int a = 0; a < N_ALU; a++) begin
      health[a] = (int'(op_class_i) < N_CLASS) ? ~permanent_faulty_i[a][op_class_i] : 1'b1;
    end
  end

  cv32e40p_alu_ft_select #(.N_ALU(N_ALU), .IW(IW)) u_select (
    .health_i   (health),
    .sel_mask_o (sel_mask),
    .h_o        (h),
    .idx_o      (idx)
  );

  logic [DATA_W-1:0] ra, rb, rc, vote_res;
  logic [N_ALU-1:0]  vote_err;
  logic              vote_unc;
  logic              ab, ac, bc;

  assign ra = result_i[idx[0]];
  assign rb = result_i[idx[1]];
  assign rc = result_i[idx[2]];
  assign ab = (ra == rb);
  assign ac = (ra == rc);
  assign bc = (rb == rc);

  always_comb begin
    vote_res = ra;
    vote_err = '0;
    vote_unc = 1'b0;
    case (h)
      2'd3: begin
        if (ab && ac) begin
          vote_res = ra;
        end else if (ab) begin
          vote_err = N_ALU'(1) << idx[2];
        end else if (ac) begin
          vote_err = N_ALU'(1) << idx[1];
        end else if (bc) begin
          vote_res = rb;
          vote_err = N_ALU'(1) << idx[0];
        end else begin
          vote_err = sel_mask;
          vote_unc = 1'b1;
        end
      end
      2'd2: begin
        if (!ab) begin
          vote_err = sel_mask;
          vote_unc = 1'b1;
        end
      end
      2'd1: vote_res = ra;
      default: begin
        vote_res = '0;
        vote_unc = 1'b1;
      end
    endcase
  end

  // Worst class decides the global mode; the mode only ever moves toward FAILED
  int unsigned min_h;
  int unsigned cls_h;
  ft_mode_e    mode_q, mode_target, mode_next;

  always_comb begin
    min_h = N_ALU;
    cls_h = 0;
    for (int c = 0; c < N_CLASS; c++) begin
      cls_h = 0;
      for (int a = 0; a < N_ALU; a++) begin
        cls_h = cls_h + {31'd0, ~permanent_faulty_i[a][c]};
      end
      if (cls_h < min_h) min_h = cls_h;
    end
    mode_target = ft_target_mode(min_h);
    mode_next   = (mode_target > mode_q) ? mode_target : mode_q;
  end

  assign mode_o = mode_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o          <= 1'b0;
      result_o         <= '0;
      error_detected_o <= '0;
      uncorrectable_o  <= 1'b0;
      alu_sel_o        <= '0;
      mode_q           <= FT_TMR_SPARE;
      mode_change_o    <= 1'b0;
      err_sticky_o     <= '0;
    end else begin
      valid_o          <= valid_i;
      result_o         <= vote_res;
      error_detected_o <= valid_i ? vote_err : '0;
      uncorrectable_o  <= valid_i & vote_unc;
      alu_sel_o        <= sel_mask;
      mode_q           <= mode_next;
      mode_change_o    <= (mode_next != mode_q);
      err_sticky_o     <= clear_sticky_i ? '0 : (err_sticky_o | error_detected_o);
    end
  end

endmodule
